dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (32-bit words, 102 deep, word index = A[13:2]) between two requesters: port 0 (CPU load/store, single word) and port 1 (loader/DMA, incrementing bursts).
- Sits between the requesters and the data RAM and owns its WE/A/WD pins.
- Performs round-robin arbitration, burst sequencing, range/alignment checking and registered read return.

Parameters:
- DW, 32, data width.
- AW, 32, byte-address width.
- DEPTH_WORDS, 102, number of valid RAM words; a word index >= DEPTH_WORDS is out of range.
- MAX_BURST, 16, maximum port-1 burst length in words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  port-0 access request
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  byte address
- m0_wdata  in  DW  write data
- m0_gnt  out  1  one-cycle pulse: access performed this cycle
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DW  registered read data
- m0_err  out  1  one-cycle pulse with gnt: access rejected
- m1_req  in  1  port-1 burst request
- m1_we  in  1  burst direction
- m1_addr  in  AW  burst start byte address
- m1_len  in  5  burst length in words; 0 is treated as 1; values >MAX_BURST are clamped to MAX_BURST
- m1_wdata  in  DW  write data, sampled during each beat
- m1_wready  out  1  high in each write-beat cycle; m1_wdata consumed that cycle
- m1_rvalid  out  1  pulse per read beat
- m1_rdata  out  DW  registered read data
- m1_done  out  1  one-cycle pulse after the final beat or on abort
- m1_err  out  1  pulse with m1_done if the burst was aborted
- ram_we  out  1  RAM write enable
- ram_a  out  AW  RAM byte address
- ram_wd  out  DW  RAM write data
- ram_rd  in  DW  RAM combinational read data

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, last_grant = 1 so port 0 wins the first tie.
  - All outputs 0.
  - Beat counter and address register cleared.
  - Reset mid-burst aborts the burst immediately, with no m1_done.
- FSM states: IDLE, P0_ACC, P1_BEAT, P1_DONE.
- IDLE:
  - Samples requests at the rising edge.
  - Only m0_req → P0_ACC. Only m1_req → P1_BEAT.
  - Both requests → the port with index != last_grant.
  - Request inputs (we, addr, wdata, len) are captured into registers at this edge. Requesters may deassert req after gnt (port 0) or done (port 1).
- P0_ACC (exactly 1 cycle):
  - Drives ram_a = captured address, ram_wd = captured data, ram_we = captured we & ok.
  - m0_gnt = 1; m0_err = !ok.
  - At the edge: if read & ok, m0_rdata <= ram_rd and m0_rvalid = 1 next cycle. Rejected read returns no rvalid.
  - last_grant <= 0; next state IDLE.
- Access check: ok = (addr[1:0] == 0) && (addr[13:2] < DEPTH_WORDS) && (addr[AW-1:14] == 0).
- P1_BEAT (one cycle per beat):
  - ram_a = cur_addr.
  - Write beat: ram_wd = m1_wdata (combinational), ram_we = ok, m1_wready = ok.
  - Read beat: m1_rdata <= ram_rd at the edge, m1_rvalid pulses the next cycle.
  - After each ok beat: cur_addr += 4, beats_left -= 1. beats_left == 1 → P1_DONE.
  - Beat not ok (start misaligned or burst runs past DEPTH_WORDS-1): no RAM write, no wready/rvalid for that beat, abort flag set, → P1_DONE.
  - Port 0 is not serviced during a burst; max port-0 wait = MAX_BURST+2 cycles.
- P1_DONE (1 cycle):
  - m1_done = 1, m1_err = abort.
  - last_grant <= 1; → IDLE.
- Throughput and latency:
  - Minimum back-to-back spacing of port-0 accesses: 2 cycles (IDLE, P0_ACC).
  - Read latency from request edge: 2 cycles to rvalid.
- Outputs when not granted:
  - ram_we = 0 in IDLE and P1_DONE.
  - ram_a and ram_wd hold 0 in IDLE.

Decomposition:
- Package dmem_arb_pkg:
  - State enum.
  - DEPTH_WORDS, MAX_BURST and the word-index slice constants.
  - addr_ok() function.
- One natural sub-module, dmem_burst_ctr: a loadable down-counter plus address incrementer with last/overflow flags.
- Arbitration and FSM stay at top level.

Test Plan:
- Port-0 write then read: m0 write addr 0x10, data 0xDEADBEEF.
  - ram_we high for exactly 1 cycle with ram_a = 0x10.
  - Subsequent read returns m0_rdata = 0xDEADBEEF, m0_rvalid 2 cycles after the request edge.
- Simultaneous requests from reset: m0 and m1 (len 4) asserted together.
  - Port 0 is granted first, then a 4-beat burst.
  - Next simultaneous request grants port 1 first.
- Burst write: m1 addr 0x100, len 4, data 1..4.
  - m1_wready high for 4 consecutive cycles.
  - RAM words 64..67 = 1..4; m1_done with m1_err = 0.
- Burst overrun: m1 read from addr 0x190 (word 100), len 4.
  - 2 rvalid beats (words 100 and 101), then m1_done with m1_err = 1.
  - No access to index 102.
- Bad single access: m0 write to 0x6 (misaligned) and to 0x198 (word 102).
  - m0_gnt and m0_err pulse together; ram_we stays 0.
- Reset mid-burst: assert rst during beat 2 of an 8-beat write burst.
  - All outputs go to 0 asynchronously; no m1_done.
  - After release, the FSM is in IDLE and a port-0 read succeeds.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// Holds the FSM state encoding, RAM geometry, burst limits and the access check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        P0_ACC  = 2'd1,
        P1_BEAT = 2'd2,
        P1_DONE = 2'd3
    } arb_state_e;

    localparam int unsigned DMEM_DEPTH_WORDS = 102;
    localparam int unsigned DMEM_MAX_BURST   = 16;
    localparam int unsigned WIDX_LO          = 2;
    localparam int unsigned WIDX_HI          = 13;
    localparam int unsigned WIDX_W           = WIDX_HI - WIDX_LO + 1;
    localparam int unsigned LEN_W            = 5;

    // A word access is legal when it is aligned, its index is in range,
    // and no address bit above the index field is set.
    function automatic logic addr_ok(input logic [1:0]        byte_off,
                                     input logic [WIDX_W-1:0] widx,
                                     input logic              upper_nz,
                                     input int unsigned       depth);
        return (byte_off == 2'b00) && (32'(widx) < depth) && !upper_nz;
    endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Burst sequencer: loadable beat down-counter plus word-address incrementer.
// Flags the final beat and a current beat address that falls outside the RAM.
module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned MAX_BURST   = DMEM_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             step_i,
    output logic [AW-1:0]    addr_o,
    output logic             last_o,
    output logic             ovf_o
);

    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic [LEN_W-1:0] len_clamped;

    // A zero length still moves one word; oversize lengths saturate.
    always_comb begin
        len_clamped = len_i;
        if (len_i == '0) begin
            len_clamped = LEN_W'(1);
        end else if (32'(len_i) > MAX_BURST) begin
            len_clamped = LEN_W'(MAX_BURST);
        end
    end

    always_comb begin
        addr_d  = addr_q;
        beats_d = beats_q;
        if (load_i) begin
            addr_d  = addr_i;
            beats_d = len_clamped;
        end else if (step_i) begin
            addr_d  = addr_q + AW'(4);
            beats_d = beats_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (beats_q == LEN_W'(1));
    assign ovf_o  = !addr_ok(addr_q[1:0], addr_q[WIDX_HI:WIDX_LO],
                             |addr_q[AW-1:WIDX_HI+1], DEPTH_WORDS);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU single-word port 0 and
// burst port 1, round-robin on ties, with registered read return on both ports.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned MAX_BURST   = DMEM_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [DW-1:0]    m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [LEN_W-1:0] m1_len,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m1_wready,
    output logic             m1_rvalid,
    output logic [DW-1:0]    m1_rdata,
    output logic             m1_done,
    output logic             m1_err,
    output logic             ram_we,
    output logic [AW-1:0]    ram_a,
    output logic [DW-1:0]    ram_wd,
    input  logic [DW-1:0]    ram_rd
);

    arb_state_e    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          p0_we_q, p0_we_d;
    logic [AW-1:0] p0_addr_q, p0_addr_d;
    logic [DW-1:0] p0_wdata_q, p0_wdata_d;
    logic          m1_we_q, m1_we_d;
    logic          abort_q, abort_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic          ctr_load, ctr_step, ctr_last, ctr_bad;
    logic [AW-1:0] cur_addr;
    logic          p0_ok, grant0, grant1;

    dmem_burst_ctr #(
        .AW          (AW),
        .DEPTH_WORDS (DEPTH_WORDS),
        .MAX_BURST   (MAX_BURST)
    ) u_burst_ctr (
        .clk    (clk),
        .rst    (rst),
        .load_i (ctr_load),
        .addr_i (m1_addr),
        .len_i  (m1_len),
        .step_i (ctr_step),
        .addr_o (cur_addr),
        .last_o (ctr_last),
        .ovf_o  (ctr_bad)
    );

    assign p0_ok  = addr_ok(p0_addr_q[1:0], p0_addr_q[WIDX_HI:WIDX_LO],
                            |p0_addr_q[AW-1:WIDX_HI+1], DEPTH_WORDS);
    // On a tie the port that did not win last time is served.
    assign grant0 = m0_req && (!m1_req || last_grant_q);
    assign grant1 = m1_req && (!m0_req || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        p0_we_d      = p0_we_q;
        p0_addr_d    = p0_addr_q;
        p0_wdata_d   = p0_wdata_q;
        m1_we_d      = m1_we_q;
        abort_d      = abort_q;
        m0_rvalid_d  = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rvalid_d  = 1'b0;
        m1_rdata_d   = m1_rdata_q;
        ctr_load     = 1'b0;
        ctr_step     = 1'b0;
        m0_gnt       = 1'b0;
        m0_err       = 1'b0;
        m1_wready    = 1'b0;
        m1_done      = 1'b0;
        m1_err       = 1'b0;
        ram_we       = 1'b0;
        ram_a        = '0;
        ram_wd       = '0;

        case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d    = P0_ACC;
                    p0_we_d    = m0_we;
                    p0_addr_d  = m0_addr;
                    p0_wdata_d = m0_wdata;
                end else if (grant1) begin
                    state_d  = P1_BEAT;
                    m1_we_d  = m1_we;
                    abort_d  = 1'b0;
                    ctr_load = 1'b1;
                end
            end
            P0_ACC: begin
                ram_a        = p0_addr_q;
                ram_wd       = p0_wdata_q;
                ram_we       = p0_we_q & p0_ok;
                m0_gnt       = 1'b1;
                m0_err       = !p0_ok;
                if (!p0_we_q && p0_ok) begin
                    m0_rvalid_d = 1'b1;
                    m0_rdata_d  = ram_rd;
                end
                last_grant_d = 1'b0;
                state_d      = IDLE;
            end
            P1_BEAT: begin
                ram_a = cur_addr;
                if (m1_we_q) begin
                    ram_wd = m1_wdata;
                end
                // An illegal beat address ends the burst without touching RAM.
                if (ctr_bad) begin
                    abort_d = 1'b1;
                    state_d = P1_DONE;
                end else begin
                    ctr_step = 1'b1;
                    if (m1_we_q) begin
                        ram_we    = 1'b1;
                        m1_wready = 1'b1;
                    end else begin
                        m1_rvalid_d = 1'b1;
                        m1_rdata_d  = ram_rd;
                    end
                    if (ctr_last) begin
                        state_d = P1_DONE;
                    end
                end
            end
            P1_DONE: begin
                m1_done      = 1'b1;
                m1_err       = abort_q;
                last_grant_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            p0_we_q      <= 1'b0;
            p0_addr_q    <= '0;
            p0_wdata_q   <= '0;
            m1_we_q      <= 1'b0;
            abort_q      <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rvalid_q  <= 1'b0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            p0_we_q      <= p0_we_d;
            p0_addr_q    <= p0_addr_d;
            p0_wdata_q   <= p0_wdata_d;
            m1_we_q      <= m1_we_d;
            abort_q      <= abort_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [4:0]  m1_len;
    logic        m1_wready, m1_rvalid, m1_done, m1_err;
    logic [31:0] m1_rdata;
    logic        ram_we;
    logic [31:0] ram_a, ram_wd, ram_rd;

    logic [31:0]  mem [0:4095];
    logic [136:0] all_outs;
    int checks = 0;
    int errors = 0;
    int oob_writes = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len),
        .m1_wdata(m1_wdata), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    assign ram_rd = mem[ram_a[13:2]];
    assign all_outs = {m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_wready, m1_rvalid,
                       m1_rdata, m1_done, m1_err, ram_we, ram_a, ram_wd};

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a[13:2]] <= ram_wd;
            if (ram_a[13:2] >= 12'd102) oob_writes++;
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_len = 0; m1_wdata = 0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_p0_write_read();
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            if (t == 0) m0_req = 0;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m0_err, ram_we} !== ((t == 0) ? 3'b101 : 3'b000)) begin
                errors++;
                $display("FAIL p0_write_ctl t=%0d: gnt/err/we %b required %b", t,
                         {m0_gnt, m0_err, ram_we}, (t == 0) ? 3'b101 : 3'b000);
            end
            checks++;
            if (ram_a !== ((t == 0) ? 32'h10 : 32'h0)) begin
                errors++;
                $display("FAIL p0_write_addr t=%0d: got %h", t, ram_a);
            end
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_write_mem: got %h required deadbeef", mem[4]);
        end
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            if (t == 0) m0_req = 0;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m0_rvalid} !== ((t == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL p0_read_ctl t=%0d: gnt/rvalid %b", t, {m0_gnt, m0_rvalid});
            end
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_read_data: got %h required deadbeef", m0_rdata);
        end
    endtask

    task automatic test_burst_write();
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_len = 5'd4; m1_wdata = 32'd1;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (t < 4) m1_wdata = 32'(t + 1);
            if (t == 4) m1_req = 0;
            @(negedge clk);
            checks++;
            if ({m1_wready, ram_we, m1_done, m1_err} !== ((t < 4) ? 4'b1100 : 4'b0010)) begin
                errors++;
                $display("FAIL bwr_ctl t=%0d: wready/we/done/err %b", t,
                         {m1_wready, ram_we, m1_done, m1_err});
            end
            if (t < 4) begin
                checks++;
                if (ram_a !== 32'h100 + 32'(4 * t) || ram_wd !== 32'(t + 1)) begin
                    errors++;
                    $display("FAIL bwr_beat t=%0d: a=%h wd=%h required a=%h wd=%h", t,
                             ram_a, ram_wd, 32'h100 + 32'(4 * t), t + 1);
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[64 + i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL bwr_mem[%0d]: got %h required %0d", 64 + i, mem[64 + i], i + 1);
            end
        end
    endtask

    task automatic test_arbitration();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h100; m1_len = 5'd4;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (t == 7) m1_req = 0;
            if (t == 9) m0_req = 0;
            @(negedge clk);
            checks++;
            if (m0_gnt !== (t == 0 || t == 8)) begin
                errors++;
                $display("FAIL arb_gnt0 t=%0d: got %b", t, m0_gnt);
            end
            checks++;
            if ({m1_rvalid, m1_done} !== {(t >= 3 && t <= 6), (t == 6)}) begin
                errors++;
                $display("FAIL arb_m1 t=%0d: rvalid/done %b", t, {m1_rvalid, m1_done});
            end
            if (t >= 3 && t <= 6) begin
                checks++;
                if (m1_rdata !== 32'(t - 2)) begin
                    errors++;
                    $display("FAIL arb_rdata t=%0d: got %h required %0d", t, m1_rdata, t - 2);
                end
            end
            if (t == 1) begin
                checks++;
                if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL arb_p0_read: rvalid=%b rdata=%h", m0_rvalid, m0_rdata);
                end
            end
        end
    endtask

    task automatic test_overrun();
        mem[100] <= 32'hCAFE0100;
        mem[101] <= 32'hCAFE0101;
        @(posedge clk); #1;
        m1_req = 1; m1_we = 0; m1_addr = 32'h190; m1_len = 5'd4;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (t == 3) m1_req = 0;
            @(negedge clk);
            checks++;
            if ({m1_rvalid, m1_done, m1_err, ram_we} !==
                {(t == 1 || t == 2), (t == 3), (t == 3), 1'b0}) begin
                errors++;
                $display("FAIL ovr_ctl t=%0d: rvalid/done/err/we %b", t,
                         {m1_rvalid, m1_done, m1_err, ram_we});
            end
            if (t == 1 || t == 2) begin
                checks++;
                if (m1_rdata !== ((t == 1) ? 32'hCAFE0100 : 32'hCAFE0101)) begin
                    errors++;
                    $display("FAIL ovr_rdata t=%0d: got %h", t, m1_rdata);
                end
            end
        end
    endtask

    task automatic test_bad_access();
        logic [31:0] addrs [3];
        logic        wes   [3];
        addrs = '{32'h6, 32'h198, 32'h198};
        wes   = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            m0_req = 1; m0_we = wes[k]; m0_addr = addrs[k]; m0_wdata = 32'h12345678;
            for (int t = 0; t < 2; t++) begin
                @(posedge clk); #1;
                if (t == 0) m0_req = 0;
                @(negedge clk);
                checks++;
                if ({m0_gnt, m0_err, ram_we, m0_rvalid} !== ((t == 0) ? 4'b1100 : 4'b0000)) begin
                    errors++;
                    $display("FAIL bad_acc k=%0d t=%0d: gnt/err/we/rvalid %b", k, t,
                             {m0_gnt, m0_err, ram_we, m0_rvalid});
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_len = 5'd8; m1_wdata = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (m1_wready !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_active: wready=%b required 1", m1_wready);
        end
        #2 rst = 1'b1;
        m1_req = 0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset_outs: got %h required 0", all_outs);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if ({m1_done, m1_wready, ram_we} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle t=%0d: done/wready/we %b", t,
                         {m1_done, m1_wready, ram_we});
            end
        end
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            if (t == 0) m0_req = 0;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m0_rvalid} !== ((t == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL post_reset_read t=%0d: gnt/rvalid %b", t, {m0_gnt, m0_rvalid});
            end
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL post_reset_rdata: got %h required deadbeef", m0_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= '0;
        test_reset();
        test_p0_write_read();
        test_burst_write();
        test_arbitration();
        test_overrun();
        test_bad_access();
        test_reset_mid_burst();
        checks++;
        if (oob_writes !== 0) begin
            errors++;
            $display("FAIL oob_writes: got %0d required 0", oob_writes);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
